fifo_to_vec_s8: RTL and testbench

FIFO_TO_VEC_S8 -- requirements
Module: fifo_to_vec_s8

---
 rtl/fifo_to_vec_s8.sv | 151 +++++++++++++++
 tb/tb_fifo_to_vec_s8.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_to_vec_s8.sv
// Packs a batch of 32-bit words carrying four s8 lanes each into VLEN-lane vectors
// and queues completed vectors in a small buffer for the consumer.
//
// state | meaning
// IDLE  | waiting for src_req with room in the vector buffer
// ACK   | one-cycle src_ack, valid count latched on entry
// RECV  | accepting VLEN/4 words into the assembly register
module fifo_to_vec_s8 #(
    parameter int VLEN  = 16,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [$clog2(VLEN)-1:0]   cfg_valid_num,
    input  logic                      src_req,
    output logic                      src_ack,
    output logic [$clog2(VLEN)-1:0]   src_valid_num,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                in_mask,
    input  logic [31:0]               in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [8*VLEN-1:0]         out_vec_s8,
    output logic [VLEN-1:0]           out_vec_mask,
    output logic                      buf_full,
    output logic                      err_mask,
    input  logic                      err_clr
);

    localparam int CW  = $clog2(VLEN);
    localparam int NW  = VLEN / 4;
    localparam int WW  = (NW > 1) ? $clog2(NW) : 1;
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CTW = $clog2(DEPTH + 1);
    localparam int NB  = 8 * VLEN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        RECV = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WW-1:0]   wcnt;
    logic [CW-1:0]   vnum;
    logic [NB-1:0]   asm_data, asm_data_nxt;
    logic [VLEN-1:0] asm_mask, asm_mask_nxt;
    logic [NB-1:0]   mem_data [DEPTH];
    logic [VLEN-1:0] mem_mask [DEPTH];
    logic [PW-1:0]   head, tail;
    logic [CTW-1:0]  count;
    logic            err_q;
    logic [3:0]      exp_mask;
    logic            accept, last, pop;
    int              wbase;

    assign wbase  = 4 * int'(wcnt);
    assign accept = (state == RECV) && in_valid;
    assign last   = accept && (wcnt == WW'(NW - 1));
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (src_req && (count < CTW'(DEPTH))) state_nxt = ACK;
            ACK:     state_nxt = RECV;
            RECV:    if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane i of the current word is expected valid while it lies below the latched count.
    always_comb begin
        exp_mask = '0;
        for (int i = 0; i < 4; i++)
            exp_mask[i] = (int'(vnum) > (wbase + i));
    end

    always_comb begin
        asm_data_nxt = asm_data;
        asm_mask_nxt = asm_mask;
        for (int i = 0; i < 4; i++) begin
            asm_data_nxt[(wbase + i)*8 +: 8] = in_mask[i] ? in_data[8*i +: 8] : 8'h00;
            asm_mask_nxt[wbase + i]          = in_mask[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wcnt     <= '0;
            vnum     <= '0;
            asm_data <= '0;
            asm_mask <= '0;
            err_q    <= 1'b0;
        end else begin
            if ((state == IDLE) && (state_nxt == ACK))
                vnum <= cfg_valid_num;
            if (accept) begin
                wcnt     <= last ? '0 : wcnt + WW'(1);
                asm_data <= last ? '0 : asm_data_nxt;
                asm_mask <= last ? '0 : asm_mask_nxt;
            end
            if (accept && (in_mask != exp_mask))
                err_q <= 1'b1;
            else if (err_clr)
                err_q <= 1'b0;
        end
    end

    // The final word is merged combinationally so the commit lands on its own handshake edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int d = 0; d < DEPTH; d++) begin
                mem_data[d] <= '0;
                mem_mask[d] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (last) begin
                mem_data[tail] <= asm_data_nxt;
                mem_mask[tail] <= asm_mask_nxt;
                tail <= (tail == PW'(DEPTH - 1)) ? '0 : tail + PW'(1);
            end
            if (pop)
                head <= (head == PW'(DEPTH - 1)) ? '0 : head + PW'(1);
            case ({last, pop})
                2'b10:   count <= count + CTW'(1);
                2'b01:   count <= count - CTW'(1);
                default: count <= count;
            endcase
        end
    end

    assign src_ack       = (state == ACK);
    assign src_valid_num = vnum;
    assign in_ready      = (state == RECV);
    assign out_valid     = (count != '0);
    assign out_vec_s8    = mem_data[head];
    assign out_vec_mask  = mem_mask[head];
    assign buf_full      = (count == CTW'(DEPTH));
    assign err_mask      = err_q;

endmodule

// File: tb/tb_fifo_to_vec_s8.sv
// Directed bench for fifo_to_vec_s8 at VLEN=16: a table of batches with
// hand-computed vectors, plus backpressure, commit/pop overlap, stall and reset sequences.
module tb_fifo_to_vec_s8;

    logic         clk = 1'b0;
    logic         rstn;
    logic [3:0]   cfg_valid_num;
    logic         src_req;
    logic         src_ack;
    logic [3:0]   src_valid_num;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_mask;
    logic [31:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_vec_s8;
    logic [15:0]  out_vec_mask;
    logic         buf_full;
    logic         err_mask;
    logic         err_clr;

    int n_chk  = 0;
    int n_fail = 0;

    fifo_to_vec_s8 #(.VLEN(16), .DEPTH(2)) dut (
        .clk(clk), .rstn(rstn), .cfg_valid_num(cfg_valid_num),
        .src_req(src_req), .src_ack(src_ack), .src_valid_num(src_valid_num),
        .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec_s8(out_vec_s8),
        .out_vec_mask(out_vec_mask), .buf_full(buf_full), .err_mask(err_mask),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Word k of a batch sits at masks[4k+:4] and data[32k+:32].
    typedef struct {
        logic [3:0]   vnum;
        logic [15:0]  masks;
        logic [127:0] data;
        logic [127:0] exp_vec;
        logic [15:0]  exp_mask;
        logic         exp_err;
        int           clr_w;
    } batch_t;

    batch_t tbl [7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_src_ack"}, src_ack, 0);
        chk({tag, "_src_valid_num"}, src_valid_num, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_vec"}, out_vec_s8, 0);
        chk({tag, "_out_mask"}, out_vec_mask, 0);
        chk({tag, "_buf_full"}, buf_full, 0);
        chk({tag, "_err_mask"}, err_mask, 0);
    endtask

    task automatic request(input int idx, output int n);
        cfg_valid_num = tbl[idx].vnum;
        src_req = 1'b1;
        n = 0;
        while (!src_ack && n < 20) begin
            tick();
            n++;
        end
        if (!src_ack) chk("ack_timeout", 0, 1);
        chk("src_valid_num", src_valid_num, tbl[idx].vnum);
        src_req = 1'b0;
        tick();
        chk("ack_one_cycle", src_ack, 0);
        chk("in_ready_recv", in_ready, 1);
    endtask

    task automatic run_words(input int idx, input int stall, input bit pop_last, input int nw);
        int n;
        for (int w = 0; w < nw; w++) begin
            if (stall > 0 && w > 0) begin
                in_valid = 1'b0;
                repeat (stall) tick();
                chk("stall_in_ready", in_ready, 1);
            end
            in_valid = 1'b1;
            in_mask  = tbl[idx].masks[4*w +: 4];
            in_data  = tbl[idx].data[32*w +: 32];
            err_clr  = (w == tbl[idx].clr_w);
            n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            if (!in_ready) chk("ready_timeout", 0, 1);
            if (pop_last && w == nw - 1) out_ready = 1'b1;
            tick();
            err_clr   = 1'b0;
            out_ready = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_head(input string tag, input int idx);
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_vec"}, out_vec_s8, tbl[idx].exp_vec);
        chk({tag, "_mask"}, out_vec_mask, tbl[idx].exp_mask);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic send_batch(input int idx);
        int n;
        request(idx, n);
        run_words(idx, 0, 1'b0, 4);
        check_head($sformatf("tbl%0d", idx), idx);
        chk($sformatf("tbl%0d_err", idx), err_mask, tbl[idx].exp_err);
        err_clr = 1'b1;
        pop_one();
        err_clr = 1'b0;
        chk($sformatf("tbl%0d_empty", idx), out_valid, 0);
        chk($sformatf("tbl%0d_err_cleared", idx), err_mask, 0);
    endtask

    initial begin
        int n;
        bit ack_leak;

        tbl[0] = '{4'd15, 16'h7FFF, 128'h0F0E0D0C_0B0A0908_07060504_03020100,
                   128'h000E0D0C_0B0A0908_07060504_03020100, 16'h7FFF, 1'b0, -1};
        tbl[1] = '{4'd8, 16'h00FF, 128'hEEFF0011_AABBCCDD_55667788_11223344,
                   128'h00000000_00000000_55667788_11223344, 16'h00FF, 1'b0, -1};
        tbl[2] = '{4'd8, 16'h0FFF, 128'h12345678_90A0B0C0_85868788_81828384,
                   128'h00000000_90A0B0C0_85868788_81828384, 16'h0FFF, 1'b1, -1};
        tbl[3] = '{4'd6, 16'h003F, 128'h05060708_01020304_CAFEF00D_DEADBEEF,
                   128'h00000000_00000000_0000F00D_DEADBEEF, 16'h003F, 1'b0, -1};
        tbl[4] = '{4'd1, 16'h0001, 128'h12345678_12345678_12345678_7F7F7F80,
                   128'h00000000_00000000_00000000_00000080, 16'h0001, 1'b0, -1};
        tbl[5] = '{4'd3, 16'h000F, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_44332211,
                   128'h00000000_00000000_00000000_44332211, 16'h000F, 1'b1, 0};
        tbl[6] = '{4'd0, 16'h0000, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
                   128'h0, 16'h0000, 1'b0, -1};

        rstn = 1'b0;
        cfg_valid_num = '0;
        src_req = 1'b0;
        in_valid = 1'b0;
        in_mask = '0;
        in_data = '0;
        out_ready = 1'b0;
        err_clr = 1'b0;
        #12;
        check_zero_outputs("reset");
        tick();
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) send_batch(i);

        // Two batches fill the buffer; a third request must wait for a pop.
        request(0, n);
        run_words(0, 0, 1'b0, 4);
        request(1, n);
        run_words(1, 0, 1'b0, 4);
        chk("bp_full", buf_full, 1);
        check_head("bp_head0", 0);
        cfg_valid_num = tbl[3].vnum;
        src_req = 1'b1;
        ack_leak = 1'b0;
        repeat (5) begin
            tick();
            if (src_ack) ack_leak = 1'b1;
        end
        chk("bp_no_ack_when_full", ack_leak, 0);
        pop_one();
        chk("bp_not_full_after_pop", buf_full, 0);
        check_head("bp_head1", 1);
        request(3, n);
        chk("bp_ack_latency", n, 1);
        run_words(3, 0, 1'b0, 4);
        chk("bp_full_again", buf_full, 1);
        pop_one();
        check_head("bp_head3", 3);
        pop_one();
        chk("bp_drained", out_valid, 0);

        // Commit and pop on the same edge with one entry already queued.
        request(0, n);
        run_words(0, 0, 1'b0, 4);
        request(4, n);
        run_words(4, 0, 1'b1, 4);
        check_head("overlap_head", 4);
        chk("overlap_not_full", buf_full, 0);
        pop_one();
        chk("overlap_drained", out_valid, 0);

        // Stalled words, then a reset in the middle of a batch.
        request(0, n);
        run_words(0, 2, 1'b0, 4);
        check_head("stall_head", 0);
        request(1, n);
        run_words(1, 1, 1'b0, 2);
        #2;
        rstn = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        tick();
        rstn = 1'b1;
        tick();
        send_batch(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
